// File: rtl/sha2_pkg.sv
// Shared definitions for the double SHA-256 datapath.
//   WORD_W         : message word width
//   NUM_WORDS_352  : words packed into one 352-bit block
//   loader_state_e : block loader FSM states
package sha2_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned NUM_WORDS_352 = 11;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

endpackage

// File: rtl/block_loader_352.sv
// Word-serial front end for the 352-bit block memory. Packs NUM_WORDS
// 32-bit words big-endian into one block and hands it off with a
// single-cycle write strobe once the downstream stage is ready.
//
// Ports:
//   CLK, RST    clock (rising edge), asynchronous active-high reset
//   clear       synchronous flush of any partial or pending block
//   in_valid    input word valid
//   in_first    accepted word is word 0 of a block
//   in_word     input message word
//   in_ready    loader can accept a word this cycle
//   dn_ready    downstream can take a block this cycle
//   write_en    one-cycle block write strobe (block_out valid with it)
//   block_out   packed block, word 0 in the most significant slot
//   word_cnt    words collected so far (0..NUM_WORDS)
//   blk_cnt     blocks handed off, wraps modulo 2^16
//   err         sticky framing error, cleared only by clear or RST
module block_loader_352
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W    = sha2_pkg::WORD_W,
    parameter int unsigned NUM_WORDS = sha2_pkg::NUM_WORDS_352,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic [WORD_W-1:0]           in_word,
    output logic                        in_ready,
    input  logic                        dn_ready,
    output logic                        write_en,
    output logic [WORD_W*NUM_WORDS-1:0] block_out,
    output logic [CNT_W-1:0]            word_cnt,
    output logic [15:0]                 blk_cnt,
    output logic                        err
);

    localparam int unsigned      BLOCK_W   = WORD_W * NUM_WORDS;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_WORDS - 1);

    loader_state_e    state_q;
    loader_state_e    state_d;
    logic             accept;
    logic             framing_bad;
    logic [CNT_W-1:0] wr_idx;

    always_comb begin
        in_ready    = (state_q == FILL) && !clear;
        write_en    = (state_q == HOLD) && dn_ready && !clear;
        accept      = in_valid && in_ready;
        // A continuation word with nothing collected has no block to join.
        framing_bad = accept && !in_first && (word_cnt == '0);
        // in_first always restarts at slot 0, whatever was collected.
        wr_idx      = in_first ? '0 : word_cnt;

        state_d = state_q;
        if (clear) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL: if (accept && !framing_bad && (wr_idx == LAST_SLOT)) state_d = HOLD;
                HOLD: if (write_en) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            block_out <= '0;
            word_cnt  <= '0;
            blk_cnt   <= '0;
            err       <= 1'b0;
        end else if (clear) begin
            // block_out and blk_cnt are deliberately left untouched.
            word_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            if (framing_bad) begin
                err <= 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                    if (wr_idx == CNT_W'(i))
                        block_out[BLOCK_W-1-i*WORD_W -: WORD_W] <= in_word;
                end
                word_cnt <= wr_idx + 1'b1;
            end
        end else if (write_en) begin
            word_cnt <= '0;
            blk_cnt  <= blk_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_block_loader_352.sv
// Randomised scoreboard bench for block_loader_352. The driver feeds
// words into a queue-based reference model; completed blocks are queued
// as expectations and a monitor pops them on every write_en.
module tb_block_loader_352;

    localparam int W  = 32;
    localparam int N  = 11;
    localparam int BW = W * N;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic [W-1:0]  in_word = '0;
    logic          in_ready;
    logic          dn_ready = 1'b0;
    logic          write_en;
    logic [BW-1:0] block_out;
    logic [3:0]    word_cnt;
    logic [15:0]   blk_cnt;
    logic          err;

    block_loader_352 #(.WORD_W(32), .NUM_WORDS(11), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .clear(clear), .in_valid(in_valid),
        .in_first(in_first), .in_word(in_word), .in_ready(in_ready),
        .dn_ready(dn_ready), .write_en(write_en), .block_out(block_out),
        .word_cnt(word_cnt), .blk_cnt(blk_cnt), .err(err)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int we_count = 0;

    // reference model
    logic [W-1:0]  words[$];
    logic [BW-1:0] exp_q[$];
    logic [15:0]   mblk = '0;
    bit            merr = 1'b0;
    bit            pending = 1'b0;
    bit            rand_dn = 1'b0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [W-1:0] w, input bit first);
        logic [BW-1:0] b;
        if (first) begin
            words.delete();
            words.push_back(w);
        end else if (words.size() == 0) begin
            merr = 1'b1;
        end else begin
            words.push_back(w);
        end
        if (words.size() == N) begin
            b = '0;
            foreach (words[i]) b = {b[BW-W-1:0], words[i]};
            exp_q.push_back(b);
        end
    endtask

    task automatic model_reset();
        words.delete();
        exp_q.delete();
        mblk = '0;
        merr = 1'b0;
        pending = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input bit first);
        int g = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_first = first;
        @(negedge CLK);
        while (!in_ready) begin
            g++;
            if (g > 300) begin
                check("send_timeout", BW'(in_ready), BW'(1));
                in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        model_accept(w, first);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_block(input logic [W-1:0] first_word);
        send(first_word, 1'b1);
        for (int i = 1; i < N; i++) send($urandom, 1'b0);
    endtask

    task automatic check_status(input string name);
        check({name, "_word_cnt"}, BW'(word_cnt), BW'(words.size()));
        check({name, "_err"},      BW'(err),      BW'(merr));
        check({name, "_blk_cnt"},  BW'(blk_cnt),  BW'(mblk));
        check({name, "_in_ready"}, BW'(in_ready), BW'(words.size() < N));
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            at_neg();
            g++;
        end
        check({name, "_drain"}, BW'(exp_q.size()), BW'(0));
        at_neg();
    endtask

    // monitor: every write_en must match the oldest expected block
    initial begin
        logic [BW-1:0] e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (pending) begin
                    check("mon_blk_cnt", BW'(blk_cnt), BW'(mblk));
                    check("mon_word_cnt_after", BW'(word_cnt), BW'(0));
                    pending = 1'b0;
                end
                if (write_en) begin
                    we_count++;
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_write", BW'(write_en), BW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("mon_block_out", block_out, e);
                    end
                    mblk = mblk + 16'd1;
                    words.delete();
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_dn) dn_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [BW-1:0] snap;

        // reset values
        #3;
        check("rst_block_out", block_out, '0);
        check("rst_write_en",  BW'(write_en), BW'(0));
        check("rst_word_cnt",  BW'(word_cnt), BW'(0));
        check("rst_blk_cnt",   BW'(blk_cnt),  BW'(0));
        check("rst_err",       BW'(err),      BW'(0));
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_in_ready", BW'(in_ready), BW'(1));

        // basic block 1..11 with downstream ready
        dn_ready = 1'b1;
        for (int i = 1; i <= N; i++) send(32'(i), i == 1);
        at_neg();
        check("basic_write_en", BW'(write_en), BW'(1));
        check("basic_word0", BW'(block_out[351:320]), BW'(32'h1));
        check("basic_word10", BW'(block_out[31:0]), BW'(32'hB));
        at_neg();
        check("basic_blk_cnt", BW'(blk_cnt), BW'(1));
        check("basic_word_cnt", BW'(word_cnt), BW'(0));

        // backpressure
        dn_ready = 1'b0;
        send_block($urandom);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("bp_in_ready", BW'(in_ready), BW'(0));
            check("bp_write_en", BW'(write_en), BW'(0));
            check("bp_word_cnt", BW'(word_cnt), BW'(11));
        end
        @(posedge CLK);
        #1;
        dn_ready = 1'b1;
        base = we_count;
        at_neg();
        check("bp_release_we", BW'(write_en), BW'(1));
        at_neg();
        check("bp_after_in_ready", BW'(in_ready), BW'(1));
        check("bp_after_we", BW'(write_en), BW'(0));
        check("bp_one_write", BW'(we_count - base), BW'(1));

        // restart mid-block
        base = we_count;
        send($urandom, 1'b1);
        for (int i = 0; i < 3; i++) send($urandom, 1'b0);
        send(32'hAAAAAAAA, 1'b1);
        for (int i = 0; i < 10; i++) send($urandom, 1'b0);
        repeat (3) at_neg();
        check("restart_writes", BW'(we_count - base), BW'(1));
        check("restart_word0", BW'(block_out[351:320]), BW'(32'hAAAAAAAA));

        // framing error
        send(32'h12345678, 1'b0);
        at_neg();
        check("frame_err", BW'(err), BW'(1));
        check("frame_word_cnt", BW'(word_cnt), BW'(0));
        send_block($urandom);
        drain("frame_block");
        check_status("frame_sticky");
        @(posedge CLK);
        #1;
        clear = 1'b1;
        @(posedge CLK);
        #1;
        clear = 1'b0;
        words.delete();
        merr = 1'b0;
        at_neg();
        check_status("frame_cleared");

        // clear during HOLD with dn_ready high
        dn_ready = 1'b0;
        send_block($urandom);
        at_neg();
        check("hold_word_cnt", BW'(word_cnt), BW'(11));
        @(posedge CLK);
        #1;
        clear = 1'b1;
        dn_ready = 1'b1;
        base = we_count;
        at_neg();
        check("clrhold_write_en", BW'(write_en), BW'(0));
        @(posedge CLK);
        #1;
        clear = 1'b0;
        dn_ready = 1'b0;
        void'(exp_q.pop_back());
        words.delete();
        merr = 1'b0;
        at_neg();
        check_status("clrhold");
        check("clrhold_no_write", BW'(we_count - base), BW'(0));

        // randomised blocks with random restarts and random dn_ready
        rand_dn = 1'b1;
        for (int b = 0; b < 10; b++) begin
            send($urandom, 1'b1);
            while (words.size() < N) send($urandom, $urandom_range(0, 9) == 0);
        end
        @(posedge CLK);
        #1;
        rand_dn = 1'b0;
        dn_ready = 1'b1;
        drain("random");
        check_status("random_end");

        // async reset mid-block
        dn_ready = 1'b0;
        send($urandom, 1'b1);
        for (int i = 0; i < 4; i++) send($urandom, 1'b0);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("arst_block_out", block_out, '0);
        check("arst_word_cnt",  BW'(word_cnt), BW'(0));
        check("arst_blk_cnt",   BW'(blk_cnt),  BW'(0));
        check("arst_err",       BW'(err),      BW'(0));
        check("arst_write_en",  BW'(write_en), BW'(0));
        model_reset();
        @(negedge CLK);
        RST = 1'b0;

        // async reset during HOLD
        send_block($urandom);
        at_neg();
        check("arst_hold_word_cnt", BW'(word_cnt), BW'(11));
        RST = 1'b1;
        dn_ready = 1'b1;
        #1;
        check("arst_hold_write_en", BW'(write_en), BW'(0));
        check("arst_hold_word_cnt0", BW'(word_cnt), BW'(0));
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        dn_ready = 1'b0;
        at_neg();
        check_status("arst_after");

        // blk_cnt wrap
        @(posedge CLK);
        #1;
        force dut.blk_cnt = 16'hFFFF;
        #1;
        release dut.blk_cnt;
        mblk = 16'hFFFF;
        dn_ready = 1'b1;
        send_block($urandom);
        drain("wrap");
        check("wrap_blk_cnt", BW'(blk_cnt), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
